// File: rtl/control_sequencer.sv
// Hardwired control unit: sequence counter, opcode decode, run flip-flop and micro-op strobes.
// Optional interrupt support (FGI/FGO/IEN/R, interrupt cycle, I/O instructions) under `INTERRUPT_EN`.
module control_sequencer #(
  parameter int DW   = 16,
  parameter int SC_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               START,
  input  logic [DW-1:0]      IR,
  input  logic               AC_SIGN,
  input  logic               AC_ZERO,
  input  logic               E_ZERO,
  input  logic               DR_ZERO,
`ifdef INTERRUPT_EN
  input  logic               FGI,
  input  logic               FGO,
  output logic               IEN,
  output logic               R,
`endif
  output logic [2**SC_W-1:0] T,
  output logic [7:0]         D,
  output logic               I,
  output logic               RUN,
  output logic [19:0]        UOP,
  output logic [11:0]        RR
);

  localparam int AR_LD_PC = 0;
  localparam int IR_LD    = 1;
  localparam int PC_INC   = 2;
  localparam int AR_LD_IR = 3;
  localparam int AR_LD_M  = 4;
  localparam int DR_LD_M  = 5;
  localparam int AC_AND   = 6;
  localparam int AC_ADD   = 7;
  localparam int AC_LD_DR = 8;
  localparam int M_WR_AC  = 9;
  localparam int PC_LD_AR = 10;
  localparam int M_WR_PC  = 11;
  localparam int AR_INC   = 12;
  localparam int DR_INC   = 13;
  localparam int M_WR_DR  = 14;
  localparam int SC_CLR   = 15;
  localparam int INT_SAVE = 16;
  localparam int INT_VEC  = 17;
  localparam int INP      = 18;
  localparam int OUT      = 19;

  logic [SC_W-1:0] sc_q, sc_nxt;
  logic            run_q, run_nxt;
  logic [7:0]      d_q, d_nxt;
  logic            i_q, i_nxt;
  logic            r_q;
  logic            skip;

`ifdef INTERRUPT_EN
  logic ien_q, ien_nxt, r_nxt;
  assign IEN = ien_q;
  assign R   = r_q;
`else
  assign r_q = 1'b0;
`endif

  assign T   = {{(2**SC_W-1){1'b0}}, 1'b1} << sc_q;
  assign D   = d_q;
  assign I   = i_q;
  assign RUN = run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q  <= '0;
      run_q <= 1'b0;
      d_q   <= '0;
      i_q   <= 1'b0;
`ifdef INTERRUPT_EN
      ien_q <= 1'b0;
      r_q   <= 1'b0;
`endif
    end else begin
      sc_q  <= sc_nxt;
      run_q <= run_nxt;
      d_q   <= d_nxt;
      i_q   <= i_nxt;
`ifdef INTERRUPT_EN
      ien_q <= ien_nxt;
      r_q   <= r_nxt;
`endif
    end
  end

  // START only matters while stopped, so a HLT in flight always wins over it.
  always_comb begin
    sc_nxt  = sc_q;
    run_nxt = run_q;
    d_nxt   = d_q;
    i_nxt   = i_q;
    if (!run_q) begin
      if (START) run_nxt = 1'b1;
    end else begin
      sc_nxt = UOP[SC_CLR] ? '0 : sc_q + SC_W'(1);
      if (!r_q && T[2]) begin
        d_nxt = 8'b1 << IR[DW-2 -: 3];
        i_nxt = IR[DW-1];
      end
      if (RR[0]) run_nxt = 1'b0;
    end
`ifdef INTERRUPT_EN
    ien_nxt = ien_q;
    r_nxt   = r_q;
    if (run_q) begin
      if (!(T[0] || T[1] || T[2]) && ien_q && (FGI || FGO)) r_nxt = 1'b1;
      if (r_q && T[2]) begin
        ien_nxt = 1'b0;
        r_nxt   = 1'b0;
      end
      if (T[3] && d_q[7] && i_q) begin
        if (IR[7]) ien_nxt = 1'b1;
        if (IR[6]) ien_nxt = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    RR   = '0;
    UOP  = '0;
    if (run_q && d_q[7] && !i_q && T[3]) RR = IR[11:0];
    skip = (RR[4] & ~AC_SIGN) | (RR[3] & AC_SIGN) | (RR[2] & AC_ZERO) | (RR[1] & E_ZERO);
    if (run_q) begin
      if (r_q) begin
        UOP[INT_SAVE] = T[0];
        UOP[INT_VEC]  = T[1];
        if (T[2]) begin
          UOP[PC_INC] = 1'b1;
          UOP[SC_CLR] = 1'b1;
        end
      end else begin
        UOP[AR_LD_PC] = T[0];
        UOP[IR_LD]    = T[1];
        UOP[PC_INC]   = T[1];
        UOP[AR_LD_IR] = T[2];
      end
      if (T[3]) begin
        if (!d_q[7]) begin
          UOP[AR_LD_M] = i_q;
        end else if (!i_q) begin
          UOP[SC_CLR] = 1'b1;
          UOP[PC_INC] = skip;
        end else begin
          UOP[SC_CLR] = 1'b1;
`ifdef INTERRUPT_EN
          UOP[INP]    = IR[11];
          UOP[OUT]    = IR[10];
          UOP[PC_INC] = (IR[9] & FGI) | (IR[8] & FGO);
`endif
        end
      end
      // Memory-reference execute phase; every path ends with SC_CLR.
      if (!d_q[7]) begin
        if (T[4]) begin
          UOP[DR_LD_M]  = d_q[0] | d_q[1] | d_q[2] | d_q[6];
          UOP[M_WR_AC]  = d_q[3];
          UOP[PC_LD_AR] = d_q[4];
          UOP[M_WR_PC]  = d_q[5];
          UOP[AR_INC]   = d_q[5];
          UOP[SC_CLR]   = d_q[3] | d_q[4];
        end
        if (T[5]) begin
          UOP[AC_AND]   = d_q[0];
          UOP[AC_ADD]   = d_q[1];
          UOP[AC_LD_DR] = d_q[2];
          UOP[PC_LD_AR] = d_q[5];
          UOP[DR_INC]   = d_q[6];
          UOP[SC_CLR]   = d_q[0] | d_q[1] | d_q[2] | d_q[5];
        end
        if (T[6] && d_q[6]) begin
          UOP[M_WR_DR] = 1'b1;
          UOP[PC_INC]  = DR_ZERO;
          UOP[SC_CLR]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: instruction vector table plus reset/HLT/interrupt sequences.
module tb_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic        START;
  logic [15:0] IR;
  logic        AC_SIGN, AC_ZERO, E_ZERO, DR_ZERO;
  logic [7:0]  T;
  logic [7:0]  D;
  logic        I;
  logic        RUN;
  logic [19:0] UOP;
  logic [11:0] RR;
`ifdef INTERRUPT_EN
  logic        FGI, FGO, IEN, R;
`endif

  int total = 0;
  int bad   = 0;

  control_sequencer #(.DW(16), .SC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .START(START), .IR(IR),
    .AC_SIGN(AC_SIGN), .AC_ZERO(AC_ZERO), .E_ZERO(E_ZERO), .DR_ZERO(DR_ZERO),
`ifdef INTERRUPT_EN
    .FGI(FGI), .FGO(FGO), .IEN(IEN), .R(R),
`endif
    .T(T), .D(D), .I(I), .RUN(RUN), .UOP(UOP), .RR(RR)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] ir;
    logic        as, az, ez, dz;
    int          ncyc;
    logic [19:0] u3, u4, u5, u6;
    logic [11:0] rr;
    logic [7:0]  d;
    logic        i;
  } vec_t;

  function automatic vec_t mk(string nm, logic [15:0] ir, logic as, logic az, logic ez,
                              logic dz, int ncyc, logic [19:0] u3, logic [19:0] u4,
                              logic [19:0] u5, logic [19:0] u6, logic [11:0] rr,
                              logic [7:0] d, logic i);
    vec_t v;
    v.nm = nm; v.ir = ir; v.as = as; v.az = az; v.ez = ez; v.dz = dz; v.ncyc = ncyc;
    v.u3 = u3; v.u4 = u4; v.u5 = u5; v.u6 = u6; v.rr = rr; v.d = d; v.i = i;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_cyc(input string nm, input int tidx, input logic [19:0] u);
    #1;
    chk({nm, "_T"}, 32'(T), 32'(1) << tidx);
    chk({nm, "_UOP"}, 32'(UOP), 32'(u));
  endtask

  localparam int NV = 15;
  vec_t v [NV];

  initial begin
    logic [19:0] eu;
    clk = 0; rst_n = 0; START = 0; IR = '0;
    AC_SIGN = 0; AC_ZERO = 0; E_ZERO = 0; DR_ZERO = 0;
`ifdef INTERRUPT_EN
    FGI = 0; FGO = 0;
`endif

    //          name       IR       as az ez dz  n  T3        T4        T5        T6        RR      D      I
    v[0]  = mk("lda",     16'h2005, 0, 0, 0, 0, 6, 20'h0,    20'h20,   20'h8100, 20'h0,    12'h0,   8'h04, 0);
    v[1]  = mk("isz_ind", 16'hE005, 0, 0, 0, 1, 7, 20'h10,   20'h20,   20'h2000, 20'hC004, 12'h0,   8'h40, 1);
    v[2]  = mk("isz_dir", 16'h6005, 0, 0, 0, 0, 7, 20'h0,    20'h20,   20'h2000, 20'hC000, 12'h0,   8'h40, 0);
    v[3]  = mk("spa_pos", 16'h7010, 0, 0, 0, 0, 4, 20'h8004, 20'h0,    20'h0,    20'h0,    12'h010, 8'h80, 0);
    v[4]  = mk("spa_neg", 16'h7010, 1, 0, 0, 0, 4, 20'h8000, 20'h0,    20'h0,    20'h0,    12'h010, 8'h80, 0);
    v[5]  = mk("and",     16'h0005, 0, 0, 0, 0, 6, 20'h0,    20'h20,   20'h8040, 20'h0,    12'h0,   8'h01, 0);
    v[6]  = mk("add",     16'h1005, 0, 0, 0, 0, 6, 20'h0,    20'h20,   20'h8080, 20'h0,    12'h0,   8'h02, 0);
    v[7]  = mk("sta",     16'h3005, 0, 0, 0, 0, 5, 20'h0,    20'h8200, 20'h0,    20'h0,    12'h0,   8'h08, 0);
    v[8]  = mk("bun",     16'h4005, 0, 0, 0, 0, 5, 20'h0,    20'h8400, 20'h0,    20'h0,    12'h0,   8'h10, 0);
    v[9]  = mk("bsa",     16'h5005, 0, 0, 0, 0, 6, 20'h0,    20'h1800, 20'h8400, 20'h0,    12'h0,   8'h20, 0);
    v[10] = mk("sza",     16'h7004, 0, 1, 0, 0, 4, 20'h8004, 20'h0,    20'h0,    20'h0,    12'h004, 8'h80, 0);
    v[11] = mk("sze",     16'h7002, 0, 0, 0, 0, 4, 20'h8000, 20'h0,    20'h0,    20'h0,    12'h002, 8'h80, 0);
    v[12] = mk("sna",     16'h7008, 1, 0, 0, 0, 4, 20'h8004, 20'h0,    20'h0,    20'h0,    12'h008, 8'h80, 0);
    v[13] = mk("cla",     16'h7800, 0, 0, 0, 0, 4, 20'h8000, 20'h0,    20'h0,    20'h0,    12'h800, 8'h80, 0);
`ifdef INTERRUPT_EN
    v[14] = mk("io_out",  16'hF400, 0, 0, 0, 0, 4, 20'h88000, 20'h0,   20'h0,    20'h0,    12'h0,   8'h80, 1);
`else
    v[14] = mk("io_nop",  16'hF400, 0, 0, 0, 0, 4, 20'h8000, 20'h0,    20'h0,    20'h0,    12'h0,   8'h80, 1);
`endif

    // Reset state, including START ignored while reset is held.
    repeat (2) @(negedge clk);
    START = 1;
    #1;
    chk("rst_T", 32'(T), 32'h1);
    chk("rst_RUN", 32'(RUN), 32'h0);
    chk("rst_UOP", 32'(UOP), 32'h0);
    chk("rst_RR", 32'(RR), 32'h0);
    chk("rst_D", 32'(D), 32'h0);
    chk("rst_I", 32'(I), 32'h0);
    @(negedge clk);
    START = 0;
    rst_n = 1;
    @(negedge clk);
    #1;
    chk("idle_RUN", 32'(RUN), 32'h0);
    expect_cyc("idle", 0, 20'h0);
    @(negedge clk);
    START = 1;
    #1;
    chk("start_RUN_pre", 32'(RUN), 32'h0);

    // Back-to-back instructions from the table.
    for (int vi = 0; vi < NV; vi++) begin
      for (int k = 0; k < v[vi].ncyc; k++) begin
        @(negedge clk);
        START = 0; IR = v[vi].ir;
        AC_SIGN = v[vi].as; AC_ZERO = v[vi].az; E_ZERO = v[vi].ez; DR_ZERO = v[vi].dz;
        case (k)
          0: eu = 20'h1;
          1: eu = 20'h6;
          2: eu = 20'h8;
          3: eu = v[vi].u3;
          4: eu = v[vi].u4;
          5: eu = v[vi].u5;
          default: eu = v[vi].u6;
        endcase
        expect_cyc(v[vi].nm, k, eu);
        chk({v[vi].nm, "_RR"}, 32'(RR), (k == 3) ? 32'(v[vi].rr) : 32'h0);
        if (k == 3) begin
          chk({v[vi].nm, "_D"}, 32'(D), 32'(v[vi].d));
          chk({v[vi].nm, "_I"}, 32'(I), 32'(v[vi].i));
        end
      end
    end
    AC_SIGN = 0; AC_ZERO = 0; E_ZERO = 0; DR_ZERO = 0;

    // HLT with START held high throughout.
    @(negedge clk); START = 1; IR = 16'h7001; expect_cyc("hlt0", 0, 20'h1);
    @(negedge clk); expect_cyc("hlt1", 1, 20'h6);
    @(negedge clk); expect_cyc("hlt2", 2, 20'h8);
    @(negedge clk); expect_cyc("hlt3", 3, 20'h8000);
    chk("hlt3_RR", 32'(RR), 32'h1);
    @(negedge clk); #1;
    chk("hlt_RUN", 32'(RUN), 32'h0);
    expect_cyc("hlt_after", 0, 20'h0);
    START = 0;
    @(negedge clk); #1;
    chk("hlt_RUN2", 32'(RUN), 32'h0);
    expect_cyc("hlt_hold", 0, 20'h0);

    // Reset pulsed during T5 of BSA.
    @(negedge clk); START = 1;
    @(negedge clk); START = 0; IR = 16'h5005; expect_cyc("bsar0", 0, 20'h1);
    @(negedge clk); expect_cyc("bsar1", 1, 20'h6);
    @(negedge clk); expect_cyc("bsar2", 2, 20'h8);
    @(negedge clk); expect_cyc("bsar3", 3, 20'h0);
    @(negedge clk); expect_cyc("bsar4", 4, 20'h1800);
    @(negedge clk); expect_cyc("bsar5", 5, 20'h8400);
    #1; rst_n = 0;
    #1;
    chk("mid_rst_UOP", 32'(UOP), 32'h0);
    chk("mid_rst_T", 32'(T), 32'h1);
    chk("mid_rst_RUN", 32'(RUN), 32'h0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    chk("post_rst_RUN", 32'(RUN), 32'h0);
    expect_cyc("post_rst", 0, 20'h0);
    @(negedge clk); #1;
    chk("post_rst_RUN2", 32'(RUN), 32'h0);
    expect_cyc("post_rst2", 0, 20'h0);

`ifdef INTERRUPT_EN
    // ION, then a flag raised during T4 of STA triggers the interrupt cycle.
    @(negedge clk); START = 1;
    @(negedge clk); START = 0; IR = 16'hF080; expect_cyc("ion0", 0, 20'h1);
    @(negedge clk); expect_cyc("ion1", 1, 20'h6);
    @(negedge clk); expect_cyc("ion2", 2, 20'h8);
    @(negedge clk); expect_cyc("ion3", 3, 20'h8000);
    @(negedge clk); IR = 16'h3005; expect_cyc("ista0", 0, 20'h1);
    chk("ion_IEN", 32'(IEN), 32'h1);
    @(negedge clk); expect_cyc("ista1", 1, 20'h6);
    @(negedge clk); expect_cyc("ista2", 2, 20'h8);
    @(negedge clk); expect_cyc("ista3", 3, 20'h0);
    chk("ista3_R", 32'(R), 32'h0);
    @(negedge clk); FGI = 1; expect_cyc("ista4", 4, 20'h8200);
    @(negedge clk); expect_cyc("rt0", 0, 20'h10000);
    chk("rt0_R", 32'(R), 32'h1);
    @(negedge clk); expect_cyc("rt1", 1, 20'h20000);
    @(negedge clk); expect_cyc("rt2", 2, 20'h8004);
    @(negedge clk); expect_cyc("rt_done", 0, 20'h1);
    chk("rt_IEN", 32'(IEN), 32'h0);
    chk("rt_R", 32'(R), 32'h0);
    FGI = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16, meaning instruction word width; legal values are 16 and above. Bit DW-1 is I, bits DW-2:DW-4 are the opcode, and bits 11:0 are B.
REQ-002 SHALL have parameter SC_W, default 3, meaning sequence-counter width; legal values are 3 and above, so T has 2**SC_W states.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port START, input, 1, a run request.
REQ-006 SHALL have port IR, input, DW, the instruction register contents.
REQ-007 SHALL have port AC_SIGN, input, 1, the AC sign bit.
REQ-008 SHALL have port AC_ZERO, input, 1, which is high when AC==0.
REQ-009 SHALL have port E_ZERO, input, 1, which is high when E==0.
REQ-010 SHALL have port DR_ZERO, input, 1, which is high when DR==0.
REQ-011 SHALL have port T, output, 2**SC_W, one-hot timing decoded from SC.
REQ-012 SHALL have port D, output, 8, opcode decode, one-hot.
REQ-013 SHALL have port I, output, 1, the indirect bit latched at T2.
REQ-014 SHALL have port RUN, output, 1, the run flip-flop S.
REQ-015 SHALL have port UOP, output, 20, micro-operation strobes as mapped in REQ-019.
REQ-016 SHALL have port RR, output, 12, register-reference strobes; bit k = r & IR[k], where r = D[7] & !I & T[3]. Bit map: 11 CLA, 10 CLE, 9 CMA, 8 CME, 7 CIR, 6 CIL, 5 INC, 4 SPA, 3 SNA, 2 SZA, 1 SZE, 0 HLT.

Function
REQ-017 SHALL hold the sequence counter SC while RUN=0, with T[0]=1 and UOP=0 and RR=0.
REQ-018 SHALL increment SC modulo 2**SC_W on each clock while RUN=1, and SHALL clear SC to 0 instead on any cycle where UOP[15] (SC_CLR) is asserted.
REQ-019 SHALL use the following UOP bit map:
- 0 AR_LD_PC, 1 IR_LD, 2 PC_INC, 3 AR_LD_IR, 4 AR_LD_M
- 5 DR_LD_M, 6 AC_AND, 7 AC_ADD, 8 AC_LD_DR, 9 M_WR_AC
- 10 PC_LD_AR, 11 M_WR_PC, 12 AR_INC, 13 DR_INC, 14 M_WR_DR
- 15 SC_CLR, 16 INT_SAVE, 17 INT_VEC, 18 INP, 19 OUT
REQ-020 SHALL run the fetch sequence:
- T0: AR_LD_PC
- T1: IR_LD and PC_INC
- T2: AR_LD_IR; register D from IR[DW-2:DW-4] and I from IR[DW-1]
D and I SHALL be stable from T3 until the next T2.
REQ-021 SHALL, at T3 with D[7]=0 and I=1, assert AR_LD_M; with D[7]=0 and I=0, assert nothing.
REQ-022 SHALL, at T3 with D[7]=1 and I=0, assert SC_CLR. It SHALL also assert PC_INC if any of these skip conditions holds:
- SPA & !AC_SIGN
- SNA & AC_SIGN
- SZA & AC_ZERO
- SZE & E_ZERO
REQ-023 SHALL, on HLT at T3, clear RUN at the next edge.
REQ-024 SHALL sequence memory-reference instructions as follows, with the last listed cycle also asserting SC_CLR:
- AND: T4 DR_LD_M; T5 AC_AND
- ADD: T4 DR_LD_M; T5 AC_ADD
- LDA: T4 DR_LD_M; T5 AC_LD_DR
- STA: T4 M_WR_AC
- BUN: T4 PC_LD_AR
- BSA: T4 M_WR_PC and AR_INC; T5 PC_LD_AR
- ISZ: T4 DR_LD_M; T5 DR_INC; T6 M_WR_DR, plus PC_INC if DR_ZERO
REQ-025 SHALL, when START is sampled high with RUN=0, set RUN and hold SC=0; START SHALL be ignored while RUN=1.
REQ-026 SHALL, when START coincides with HLT, let HLT win.
REQ-027 SHALL produce UOP and RR combinationally from registered state and the inputs only.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set SC=0, RUN=0, D=0 and I=0, and SHALL force UOP=0 and RR=0.
REQ-029 SHALL, when reset is asserted mid-instruction, abandon the instruction; after release the block idles at T0 until START.

Configuration
REQ-030 SHALL, when INTERRUPT_EN is defined, add input FGI (1), input FGO (1), output IEN (1) and output R (1); otherwise these ports SHALL be absent and UOP[19:16] SHALL be tied 0.
REQ-031 SHALL, with INTERRUPT_EN defined, set R when RUN=1, SC is not in T0..T2, IEN=1 and (FGI | FGO).
REQ-032 SHALL, with INTERRUPT_EN defined and R=1, run the interrupt cycle in place of fetch:
- RT0: INT_SAVE
- RT1: INT_VEC
- RT2: PC_INC and SC_CLR; clear IEN and R
REQ-033 SHALL, with INTERRUPT_EN defined, decode D[7]=1 with I=1 at T3 as follows, each with SC_CLR:
- B[11] INP
- B[10] OUT
- B[9] SKI: PC_INC if FGI
- B[8] SKO: PC_INC if FGO
- B[7] ION: set IEN
- B[6] IOF: clear IEN
REQ-034 SHALL, without INTERRUPT_EN, treat D[7]=1 with I=1 as a NOP that asserts SC_CLR at T3.

Verification
REQ-035 SHALL cover: reset, then START pulse, then IR=16'h2005 (LDA direct) -> T0..T5 strobe correctly, DR_LD_M at T4, AC_LD_DR|SC_CLR at T5, and T[0] in the next cycle.
REQ-036 SHALL cover: IR=16'hE005 (ISZ indirect) with DR_ZERO=1 at T6 -> AR_LD_M at T3, DR_INC at T5, M_WR_DR|PC_INC|SC_CLR at T6.
REQ-037 SHALL cover: IR=16'h7010 (SPA) with AC_SIGN=0 -> RR[4]=1, PC_INC=1, SC_CLR=1 at T3; repeated with AC_SIGN=1 -> PC_INC=0.
REQ-038 SHALL cover: IR=16'h7001 (HLT) with START held high -> RUN=0 after the T3 edge, and SC stays 0.
REQ-039 SHALL cover: rst_n pulsed low during T5 of BSA -> UOP=0 immediately, and SC=0 and RUN=0 after release.
REQ-040 SHALL cover, with INTERRUPT_EN defined: ION executed, then FGI=1 during T4 of STA -> R=1, then INT_SAVE, INT_VEC, then PC_INC|SC_CLR with IEN=0.
